// File: rtl/alu_op_sequencer.sv
// Command FIFO and issue stage feeding the 16-bit accumulator ALU breadboard.
// Issues one queued command per clock, NO-OP when idle, halts on breadboard error.
module alu_op_sequencer #(
   parameter int DEPTH  = 8,
   parameter int DATA_W = 16,
   parameter int OP_W   = 4,
   localparam int CW    = $clog2(DEPTH + 1),
   localparam int PW    = $clog2(DEPTH)
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              InValid,
   output logic              InReady,
   input  logic [OP_W-1:0]   InOpCode,
   input  logic [DATA_W-1:0] InOperand,
   input  logic              Flush,
   input  logic              ErrClear,
   input  logic [1:0]        Error,
   output logic [OP_W-1:0]   OutOpCode,
   output logic [DATA_W-1:0] OutInputA,
   output logic              OutIssued,
   output logic [1:0]        ErrSticky,
   output logic              Halted,
   output logic [CW-1:0]     Count,
   output logic [15:0]       IssueCnt
);

   typedef enum logic {RUN, HALT} state_t;

   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   state_t                   state_q, state_d;
   logic [OP_W+DATA_W-1:0]   mem_q [DEPTH];
   logic [PW-1:0]            wr_q, wr_d;
   logic [PW-1:0]            rd_q, rd_d;
   logic [CW-1:0]            count_q, count_d;
   logic [OP_W-1:0]          op_q, op_d;
   logic [DATA_W-1:0]        a_q, a_d;
   logic                     iss_q, iss_d;
   logic [1:0]               sticky_q, sticky_d;
   logic [15:0]              icnt_q, icnt_d;
   logic                     err, push, pop, wr_en;

   assign InReady = (count_q != FULL);

   always_comb begin
      state_d  = state_q;
      wr_d     = wr_q;
      rd_d     = rd_q;
      count_d  = count_q;
      op_d     = '0;
      a_d      = '0;
      iss_d    = 1'b0;
      sticky_d = sticky_q;
      icnt_d   = icnt_q;
      wr_en    = 1'b0;

      // Only a real command on the bus can fault; filler NO-OPs cannot.
      err  = iss_q & (|Error);
      push = InValid & InReady;
      pop  = (state_q == RUN) & (count_q != '0) & ~err & ~Flush;

      if (Flush) begin
         wr_d    = '0;
         rd_d    = '0;
         count_d = '0;
      end else begin
         if (pop) begin
            {op_d, a_d} = mem_q[rd_q];
            iss_d       = 1'b1;
            rd_d        = rd_q + 1'b1;
            icnt_d      = icnt_q + 16'd1;
         end
         if (push) begin
            wr_en = 1'b1;
            wr_d  = wr_q + 1'b1;
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end

      if (err) begin
         sticky_d = Error;
         state_d  = HALT;
      end else if (ErrClear) begin
         sticky_d = '0;
         state_d  = RUN;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q  <= RUN;
         wr_q     <= '0;
         rd_q     <= '0;
         count_q  <= '0;
         op_q     <= '0;
         a_q      <= '0;
         iss_q    <= 1'b0;
         sticky_q <= '0;
         icnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         wr_q     <= wr_d;
         rd_q     <= rd_d;
         count_q  <= count_d;
         op_q     <= op_d;
         a_q      <= a_d;
         iss_q    <= iss_d;
         sticky_q <= sticky_d;
         icnt_q   <= icnt_d;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset && wr_en)
         mem_q[wr_q] <= {InOpCode, InOperand};
   end

   assign OutOpCode = op_q;
   assign OutInputA = a_q;
   assign OutIssued = iss_q;
   assign ErrSticky = sticky_q;
   assign Halted    = (state_q == HALT);
   assign Count     = count_q;
   assign IssueCnt  = icnt_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed scenarios plus random traffic,
// all checked every cycle against a queue-based reference model.
module tb_alu_op_sequencer;

   localparam int DEPTH = 8;

   logic        Clk;
   logic        Reset;
   logic        InValid;
   logic        InReady;
   logic [3:0]  InOpCode;
   logic [15:0] InOperand;
   logic        Flush;
   logic        ErrClear;
   logic [1:0]  Error;
   logic [3:0]  OutOpCode;
   logic [15:0] OutInputA;
   logic        OutIssued;
   logic [1:0]  ErrSticky;
   logic        Halted;
   logic [3:0]  Count;
   logic [15:0] IssueCnt;

   alu_op_sequencer #(.DEPTH(DEPTH), .DATA_W(16), .OP_W(4)) dut (
      .Clk(Clk), .Reset(Reset),
      .InValid(InValid), .InReady(InReady),
      .InOpCode(InOpCode), .InOperand(InOperand),
      .Flush(Flush), .ErrClear(ErrClear), .Error(Error),
      .OutOpCode(OutOpCode), .OutInputA(OutInputA),
      .OutIssued(OutIssued), .ErrSticky(ErrSticky),
      .Halted(Halted), .Count(Count), .IssueCnt(IssueCnt)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int passed = 0;
   int total  = 0;
   int fails  = 0;

   // Reference model: queue contents plus observable registers
   logic [19:0] mq[$];
   logic        m_halt;
   logic [1:0]  m_sticky;
   logic [3:0]  m_op;
   logic [15:0] m_a;
   logic        m_iss;
   logic [15:0] m_icnt;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("OutOpCode", 32'(OutOpCode), 32'(m_op));
      chk("OutInputA", 32'(OutInputA), 32'(m_a));
      chk("OutIssued", 32'(OutIssued), 32'(m_iss));
      chk("ErrSticky", 32'(ErrSticky), 32'(m_sticky));
      chk("Halted", 32'(Halted), 32'(m_halt));
      chk("Count", 32'(Count), 32'(mq.size()));
      chk("IssueCnt", 32'(IssueCnt), 32'(m_icnt));
      chk("InReady", 32'(InReady), 32'(mq.size() < DEPTH));
   endtask

   task automatic step(input logic v, input logic [3:0] op,
                       input logic [15:0] opd, input logic fl,
                       input logic clr, input logic [1:0] er,
                       input logic rst);
      logic        e, p, rdy;
      logic [19:0] h;
      InValid   = v;
      InOpCode  = op;
      InOperand = opd;
      Flush     = fl;
      ErrClear  = clr;
      Error     = er;
      Reset     = rst;
      if (rst) begin
         mq.delete();
         m_halt = 1'b0; m_sticky = 2'b00;
         m_op = '0; m_a = '0; m_iss = 1'b0; m_icnt = '0;
      end else begin
         e   = m_iss && (er != 2'b00);
         p   = !m_halt && (mq.size() > 0) && !e && !fl;
         rdy = (mq.size() < DEPTH);
         m_op = '0; m_a = '0; m_iss = 1'b0;
         if (fl) mq.delete();
         else begin
            if (p) begin
               h = mq.pop_front();
               m_op = h[19:16]; m_a = h[15:0];
               m_iss = 1'b1; m_icnt = m_icnt + 16'd1;
            end
            if (v && rdy) mq.push_back({op, opd});
         end
         if (e) begin
            m_sticky = er; m_halt = 1'b1;
         end else if (clr) begin
            m_sticky = 2'b00; m_halt = 1'b0;
         end
      end
      @(posedge Clk);
      #1;
      check_all();
   endtask

   task automatic idle();
      step(1'b0, 4'h0, 16'h0, 1'b0, 1'b0, 2'b00, 1'b0);
   endtask

   task automatic push(input logic [3:0] op, input logic [15:0] opd);
      step(1'b1, op, opd, 1'b0, 1'b0, 2'b00, 1'b0);
   endtask

   // From RUN with an empty queue: issue one command and fault on it
   task automatic halt_with(input logic [1:0] er);
      push(4'h3, 16'h1234);
      idle();
      step(1'b0, 4'h0, 16'h0, 1'b0, 1'b0, er, 1'b0);
   endtask

   initial begin
      logic [1:0] er;
      m_halt = 1'b0; m_sticky = '0; m_op = '0; m_a = '0;
      m_iss = 1'b0; m_icnt = '0;
      step(1'b0, 4'h0, 16'h0, 1'b0, 1'b0, 2'b00, 1'b1);
      step(1'b0, 4'h0, 16'h0, 1'b0, 1'b0, 2'b00, 1'b1);
      chk("rst_ready", 32'(InReady), 32'd1);

      // 1: back-to-back pushes issue in order, first one two cycles later
      push(4'h1, 16'd0);
      chk("t1_idle", 32'(OutIssued), 32'd0);
      push(4'h4, 16'd250);
      chk("t1_op0", 32'(OutOpCode), 32'h1);
      push(4'h6, 16'd150);
      chk("t1_op1", 32'(OutOpCode), 32'h4);
      push(4'h7, 16'd31000);
      chk("t1_op2", 32'(OutOpCode), 32'h6);
      idle();
      chk("t1_op3", 32'(OutOpCode), 32'h7);
      chk("t1_a3", 32'(OutInputA), 32'd31000);
      chk("t1_cnt", 32'(IssueCnt), 32'd4);
      idle();
      chk("t1_nop", 32'({OutIssued, OutOpCode}), 32'h0);

      // 2: fill while halted; ninth push is dropped
      halt_with(2'b01);
      for (int i = 0; i < DEPTH + 1; i++) push(4'(i), 16'(i * 3));
      chk("t2_count", 32'(Count), 32'd8);
      chk("t2_ready", 32'(InReady), 32'd0);

      // 3: overflow on the 0101 command halts with 1010 still queued
      step(1'b0, 4'h0, 16'h0, 1'b1, 1'b0, 2'b00, 1'b0);
      step(1'b0, 4'h0, 16'h0, 1'b0, 1'b1, 2'b00, 1'b0);
      push(4'h2, 16'h0000);
      push(4'h5, 16'hFFFF);
      push(4'hA, 16'h0001);
      chk("t3_op5", 32'(OutOpCode), 32'h5);
      er = (m_iss && m_op == 4'h5) ? 2'b01 : 2'b00;
      step(1'b0, 4'h0, 16'h0, 1'b0, 1'b0, er, 1'b0);
      chk("t3_sticky", 32'(ErrSticky), 32'h1);
      chk("t3_halt", 32'(Halted), 32'd1);
      chk("t3_nop", 32'(OutOpCode), 32'h0);
      chk("t3_left", 32'(Count), 32'd1);
      step(1'b0, 4'h0, 16'h0, 1'b0, 1'b1, 2'b00, 1'b0);
      idle();
      chk("t3_resume", 32'(OutOpCode), 32'hA);

      // 4: steady push+pop at depth 3 across pointer wrap
      idle();
      halt_with(2'b10);
      for (int i = 0; i < 3; i++) push(4'(i + 8), 16'(i + 100));
      step(1'b0, 4'h0, 16'h0, 1'b0, 1'b1, 2'b00, 1'b0);
      for (int i = 0; i < 20; i++) push(4'(i), 16'($urandom));
      chk("t4_count", 32'(Count), 32'd3);
      for (int i = 0; i < 4; i++) idle();

      // 5: flush beats a simultaneous push at depth 5
      halt_with(2'b01);
      for (int i = 0; i < 5; i++) push(4'hC, 16'(i));
      step(1'b1, 4'hD, 16'hBEEF, 1'b1, 1'b0, 2'b00, 1'b0);
      chk("t5_count", 32'(Count), 32'd0);
      chk("t5_nop", 32'({OutIssued, OutOpCode, OutInputA}), 32'h0);
      step(1'b0, 4'h0, 16'h0, 1'b0, 1'b1, 2'b00, 1'b0);

      // 6: reset in HALT with sticky 10
      halt_with(2'b10);
      push(4'h9, 16'h5555);
      push(4'h8, 16'hAAAA);
      chk("t6_pre", 32'({Halted, ErrSticky}), 32'h6);
      step(1'b0, 4'h0, 16'h0, 1'b0, 1'b0, 2'b00, 1'b1);
      chk("t6_halt", 32'(Halted), 32'd0);
      chk("t6_all", 32'({ErrSticky, Count, IssueCnt}), 32'h0);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         logic v, fl, clr, rst;
         v   = ($urandom_range(0, 9) < 7);
         fl  = ($urandom_range(0, 49) == 0);
         clr = ($urandom_range(0, 9) == 0);
         rst = ($urandom_range(0, 149) == 0);
         er  = 2'b00;
         if ($urandom_range(0, 19) == 0) er = 2'($urandom_range(1, 3));
         step(v, 4'($urandom), 16'($urandom), fl, clr, er, rst);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
